// File: rtl/cpu_irq_pkg.sv
// Shared definitions for the interrupt controller: CSR map, cause base,
// reset constants, FSM state type and timer CSR address helpers.
package cpu_irq_pkg;

    localparam logic [12:0] CSR_IPEND    = 13'h010;
    localparam logic [12:0] CSR_IMASK    = 13'h011;
    localparam logic [12:0] CSR_ICAUSE   = 13'h012;
    localparam logic [12:0] CSR_INTVEC   = 13'h013;
    localparam logic [12:0] CSR_TCOUNT0  = 13'h020;
    localparam logic [12:0] CSR_TRELOAD0 = 13'h021;

    localparam logic [7:0]  CAUSE_IRQ_BASE = 8'h80;
    localparam logic [31:0] INTVEC_RESET   = 32'hffff0008;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACTIVE
    } irq_state_e;

    function automatic logic [12:0] tcount_addr(input int k);
        return CSR_TCOUNT0 + 13'(2 * k);
    endfunction

    function automatic logic [12:0] treload_addr(input int k);
        return CSR_TRELOAD0 + 13'(2 * k);
    endfunction

endpackage

// File: rtl/cpu_irq_timer.sv
// One reloadable countdown timer. Ports: clock/reset, count_we/reload_we
// with wdata, count/reload readback, expire (high while count == 1).
module cpu_irq_timer #(
    parameter int TIMER_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               count_we,
    input  logic               reload_we,
    input  logic [TIMER_W-1:0] wdata,
    output logic [TIMER_W-1:0] count,
    output logic [TIMER_W-1:0] reload,
    output logic               expire
);

    logic [TIMER_W-1:0] count_q, count_d;
    logic [TIMER_W-1:0] reload_q, reload_d;

    // A count of zero is the stopped state; a software load wins over
    // the decrement but the expiry of the old value is still reported.
    always_comb begin
        count_d  = count_q;
        reload_d = reload_q;
        if (count_we) begin
            count_d = wdata;
        end else if (count_q == TIMER_W'(1)) begin
            count_d = reload_q;
        end else if (count_q != '0) begin
            count_d = count_q - TIMER_W'(1);
        end
        if (reload_we) begin
            reload_d = wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '1;
            reload_q <= '0;
        end else begin
            count_q  <= count_d;
            reload_q <= reload_d;
        end
    end

    assign count  = count_q;
    assign reload = reload_q;
    assign expire = (count_q == TIMER_W'(1));

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Interrupt controller: NUM_TIMERS timers + NUM_EXT edge lines, pending/mask,
// fixed priority, req/ack handshake to P4, CSRs with registered readback.
// Ports: clock, reset, stall, csr_* (P3 access, rdata in P4), irq_in,
// global_ie, irq_req/irq_cause/irq_vector, irq_ack, irq_rti.
// Option: define CPU_IRQ_VECTORED_EN for per-source vector offsets.
module cpu_irq_ctrl
    import cpu_irq_pkg::*;
#(
    parameter int NUM_EXT    = 4,
    parameter int NUM_TIMERS = 2,
    parameter int TIMER_W    = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               csr_we,
    input  logic               csr_re,
    input  logic [12:0]        csr_addr,
    input  logic [31:0]        csr_wdata,
    output logic [31:0]        csr_rdata,
    input  logic [NUM_EXT-1:0] irq_in,
    input  logic               global_ie,
    output logic               irq_req,
    output logic [7:0]         irq_cause,
    output logic [31:0]        irq_vector,
    input  logic               irq_ack,
    input  logic               irq_rti
);

    localparam int NUM_SRC = NUM_TIMERS + NUM_EXT;
    localparam int SEL_W   = 5;

    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] imask_q, imask_d;
    logic [7:0]         icause_q, icause_d;
    logic [31:0]        intvec_q, intvec_d;
    logic [NUM_EXT-1:0] irq_in_q;
    irq_state_e         state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [31:0]        rdata_q, rdata_d;

    logic               wr_en;
    logic [NUM_SRC-1:0] hw_set;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] sel_oh;
    logic               sel_active;
    logic [SEL_W-1:0]   prio_idx;
    logic               accept;
    logic [7:0]         cause_w;
    logic [31:0]        rd_val;

    logic [TIMER_W-1:0]    t_count  [NUM_TIMERS];
    logic [TIMER_W-1:0]    t_reload [NUM_TIMERS];
    logic [NUM_TIMERS-1:0] t_expire;
    logic [NUM_TIMERS-1:0] t_cwe;
    logic [NUM_TIMERS-1:0] t_rwe;

    assign wr_en = csr_we & ~stall;

    for (genvar k = 0; k < NUM_TIMERS; k++) begin : g_timer
        assign t_cwe[k] = wr_en && (csr_addr == tcount_addr(k));
        assign t_rwe[k] = wr_en && (csr_addr == treload_addr(k));
        cpu_irq_timer #(
            .TIMER_W (TIMER_W)
        ) u_timer (
            .clock     (clock),
            .reset     (reset),
            .count_we  (t_cwe[k]),
            .reload_we (t_rwe[k]),
            .wdata     (csr_wdata[TIMER_W-1:0]),
            .count     (t_count[k]),
            .reload    (t_reload[k]),
            .expire    (t_expire[k])
        );
    end

    assign hw_set = {irq_in & ~irq_in_q, t_expire};
    assign active = pend_q & imask_q & {NUM_SRC{global_ie}};

    // Descending scan so the lowest active index is the one left over.
    always_comb begin
        prio_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                prio_idx = SEL_W'(i);
            end
        end
    end

    assign sel_oh     = NUM_SRC'(1) << sel_q;
    assign sel_active = |(active & sel_oh);
    assign cause_w    = CAUSE_IRQ_BASE | {3'b000, sel_q};

    // The latched source is not re-arbitrated in REQ; it is only dropped
    // if it stops being active (cleared, masked or globally disabled).
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if ((|active) && !stall) begin
                    state_d = ST_REQ;
                    sel_d   = prio_idx;
                end
            end
            ST_REQ: begin
                if (!sel_active) begin
                    state_d = ST_IDLE;
                end else if (irq_ack && !stall) begin
                    state_d = ST_ACTIVE;
                    accept  = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (irq_rti) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Hardware sets beat a W1C; the ack clear beats everything.
    always_comb begin
        pend_d   = pend_q;
        imask_d  = imask_q;
        icause_d = icause_q;
        intvec_d = intvec_q;
        if (wr_en && csr_addr == CSR_IPEND) begin
            pend_d = pend_d & ~csr_wdata[NUM_SRC-1:0];
        end
        pend_d = pend_d | hw_set;
        if (accept) begin
            pend_d   = pend_d & ~sel_oh;
            icause_d = cause_w;
        end
        if (wr_en && csr_addr == CSR_IMASK) begin
            imask_d = csr_wdata[NUM_SRC-1:0];
        end
        if (wr_en && csr_addr == CSR_INTVEC) begin
`ifdef CPU_IRQ_VECTORED_EN
            intvec_d = {csr_wdata[31:4], 4'h0};
`else
            intvec_d = csr_wdata;
`endif
        end
    end

    // Readback uses pre-write values, so a same-cycle write returns old data.
    always_comb begin
        rd_val = '0;
        case (csr_addr)
            CSR_IPEND:  rd_val = 32'(pend_q);
            CSR_IMASK:  rd_val = 32'(imask_q);
            CSR_ICAUSE: rd_val = 32'(icause_q);
            CSR_INTVEC: rd_val = intvec_q;
            default:    rd_val = '0;
        endcase
        for (int k = 0; k < NUM_TIMERS; k++) begin
            if (csr_addr == tcount_addr(k)) begin
                rd_val = 32'(t_count[k]);
            end
            if (csr_addr == treload_addr(k)) begin
                rd_val = 32'(t_reload[k]);
            end
        end
        rdata_d = rdata_q;
        if (!stall) begin
            rdata_d = csr_re ? rd_val : '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q   <= '0;
            imask_q  <= '0;
            icause_q <= '0;
            intvec_q <= INTVEC_RESET;
            irq_in_q <= '0;
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            rdata_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            imask_q  <= imask_d;
            icause_q <= icause_d;
            intvec_q <= intvec_d;
            irq_in_q <= irq_in;
            state_q  <= state_d;
            sel_q    <= sel_d;
            rdata_q  <= rdata_d;
        end
    end

    assign irq_req   = (state_q == ST_REQ) && sel_active;
    assign irq_cause = (state_q == ST_REQ) ? cause_w : 8'h00;
    assign csr_rdata = rdata_q;

`ifdef CPU_IRQ_VECTORED_EN
    assign irq_vector = intvec_q + ({27'b0, sel_q} << 4);
`else
    assign irq_vector = intvec_q;
`endif

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Randomized bench for cpu_irq_ctrl against a behavioural model,
// plus short directed sequences for timer, priority, stall, withdraw.
module tb_cpu_irq_ctrl;
    import cpu_irq_pkg::*;

    localparam int NE = 4;
    localparam int NT = 2;
    localparam int NS = NE + NT;
    localparam int TW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic          stall;
    logic          csr_we;
    logic          csr_re;
    logic [12:0]   csr_addr;
    logic [31:0]   csr_wdata;
    logic [31:0]   csr_rdata;
    logic [NE-1:0] irq_in;
    logic          global_ie;
    logic          irq_req;
    logic [7:0]    irq_cause;
    logic [31:0]   irq_vector;
    logic          irq_ack;
    logic          irq_rti;

    always #5 clock = ~clock;

    cpu_irq_ctrl #(
        .NUM_EXT    (NE),
        .NUM_TIMERS (NT),
        .TIMER_W    (TW)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .csr_we     (csr_we),
        .csr_re     (csr_re),
        .csr_addr   (csr_addr),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .irq_in     (irq_in),
        .global_ie  (global_ie),
        .irq_req    (irq_req),
        .irq_cause  (irq_cause),
        .irq_vector (irq_vector),
        .irq_ack    (irq_ack),
        .irq_rti    (irq_rti)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    // Reference model: sources, handshake flags, CSR contents.
    logic [TW-1:0] m_cnt [NT];
    logic [TW-1:0] m_rld [NT];
    logic [NS-1:0] m_pend, m_mask;
    logic [7:0]    m_icause;
    logic [31:0]   m_vbase, m_rdata;
    logic [NE-1:0] m_prev;
    bit            m_wait_ack, m_in_isr;
    int            m_sel;

    function automatic logic [NS-1:0] m_active();
        return m_pend & m_mask & {NS{global_ie}};
    endfunction

    task automatic model_edge();
        logic [NS-1:0] act;
        logic [NS-1:0] set;
        logic [31:0]   rd;
        bit            wr;
        bit            take;
        if (reset) begin
            for (int k = 0; k < NT; k++) begin
                m_cnt[k] = '1;
                m_rld[k] = '0;
            end
            m_pend = 0; m_mask = 0; m_icause = 0;
            m_vbase = 32'hffff0008; m_rdata = 0; m_prev = 0;
            m_wait_ack = 0; m_in_isr = 0; m_sel = 0;
            return;
        end
        act  = m_active();
        set  = 0;
        rd   = 0;
        take = 0;
        wr   = csr_we && !stall;
        if (csr_addr == 13'h010) rd = 32'(m_pend);
        if (csr_addr == 13'h011) rd = 32'(m_mask);
        if (csr_addr == 13'h012) rd = 32'(m_icause);
        if (csr_addr == 13'h013) rd = m_vbase;
        for (int k = 0; k < NT; k++) begin
            if (csr_addr == 13'(32 + 2 * k)) rd = 32'(m_cnt[k]);
            if (csr_addr == 13'(33 + 2 * k)) rd = 32'(m_rld[k]);
            if (m_cnt[k] == 1) set[k] = 1'b1;
        end
        for (int i = 0; i < NE; i++)
            if (irq_in[i] && !m_prev[i]) set[NT+i] = 1'b1;
        if (m_in_isr) begin
            if (irq_rti) m_in_isr = 0;
        end else if (m_wait_ack) begin
            if (!act[m_sel]) begin
                m_wait_ack = 0;
            end else if (irq_ack && !stall) begin
                take = 1; m_wait_ack = 0; m_in_isr = 1;
                m_icause = 8'(128 + m_sel);
            end
        end else if (act != 0 && !stall) begin
            for (int i = NS - 1; i >= 0; i--) if (act[i]) m_sel = i;
            m_wait_ack = 1;
        end
        if (wr && csr_addr == 13'h010) m_pend = m_pend & ~csr_wdata[NS-1:0];
        m_pend = m_pend | set;
        if (take) m_pend[m_sel] = 1'b0;
        if (wr && csr_addr == 13'h011) m_mask = csr_wdata[NS-1:0];
        if (wr && csr_addr == 13'h013) begin
`ifdef CPU_IRQ_VECTORED_EN
            m_vbase = csr_wdata & 32'hfffffff0;
`else
            m_vbase = csr_wdata;
`endif
        end
        for (int k = 0; k < NT; k++) begin
            if (wr && csr_addr == 13'(32 + 2 * k)) m_cnt[k] = csr_wdata[TW-1:0];
            else if (m_cnt[k] == 1) m_cnt[k] = m_rld[k];
            else if (m_cnt[k] != 0) m_cnt[k] = m_cnt[k] - 1;
            if (wr && csr_addr == 13'(33 + 2 * k)) m_rld[k] = csr_wdata[TW-1:0];
        end
        m_prev = irq_in;
        if (!stall) m_rdata = csr_re ? rd : 32'h0;
    endtask

    task automatic check_outputs();
        logic [NS-1:0] act;
        logic [31:0]   vec;
        act = m_active();
`ifdef CPU_IRQ_VECTORED_EN
        vec = m_vbase + 32'(m_sel * 16);
`else
        vec = m_vbase;
`endif
        check("req", irq_req, m_wait_ack && act[m_sel]);
        check("cause", irq_cause, m_wait_ack ? 32'(128 + m_sel) : 32'h0);
        check("vector", irq_vector, vec);
        check("rdata", csr_rdata, m_rdata);
    endtask

    task automatic step();
        model_edge();
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic idle_in();
        stall = 0; csr_we = 0; csr_re = 0; csr_addr = 0;
        csr_wdata = 0; irq_ack = 0; irq_rti = 0;
    endtask

    task automatic wr_csr(input logic [12:0] a, input logic [31:0] d);
        idle_in();
        csr_we = 1; csr_addr = a; csr_wdata = d;
        step();
        idle_in();
    endtask

    task automatic rd_csr(input logic [12:0] a, output logic [31:0] d);
        idle_in();
        csr_re = 1; csr_addr = a;
        step();
        d = csr_rdata;
        idle_in();
    endtask

    task automatic wait_req(input string tag, output int n);
        n = 0;
        while (!irq_req && n < 30) begin
            step();
            n++;
        end
        check(tag, irq_req, 1'b1);
    endtask

    task automatic ack_rti();
        irq_ack = 1; step(); idle_in();
        irq_rti = 1; step(); idle_in();
    endtask

    logic [31:0] d;
    int          n;

    initial begin
        reset = 1; irq_in = 0; global_ie = 0;
        idle_in();
        #1;
        step(); step();
        check("rst_req", irq_req, 1'b0);
        check("rst_cause", irq_cause, 32'h0);
        check("rst_vec", irq_vector, 32'hffff0008);
        check("rst_rdata", csr_rdata, 32'h0);
        reset = 0;
        rd_csr(CSR_TCOUNT0, d);
        check("rst_tcount", d, 32'hffffffff);

        // timer 0 fire and reload
        global_ie = 1;
        wr_csr(CSR_IMASK, 32'h1);
        wr_csr(CSR_TRELOAD0, 32'd5);
        wr_csr(CSR_TCOUNT0, 32'd3);
        wait_req("t0_req", n);
        check("t0_lat", n, 4);
        check("t0_cause", irq_cause, 32'h80);
        ack_rti();
        wait_req("t0_req2", n);
        check("t0_cause2", irq_cause, 32'h80);
        ack_rti();
        rd_csr(CSR_ICAUSE, d);
        check("icause_t0", d, 32'h80);
        wr_csr(CSR_TCOUNT0, 32'd0);
        wr_csr(CSR_IPEND, 32'hffffffff);

        // mask readback and set/clear collision
        wr_csr(CSR_IMASK, 32'hffffffff);
        rd_csr(CSR_IMASK, d);
        check("imask_rb", d, 32'h3f);
        global_ie = 0;
        irq_in[0] = 1;
        wr_csr(CSR_IPEND, 32'h4);
        rd_csr(CSR_IPEND, d);
        check("collide", (d >> 2) & 32'h1, 32'h1);
        irq_in = 0;
        wr_csr(CSR_IPEND, 32'hffffffff);

        // priority: timer1 beats external line 1
        irq_in[1] = 1;
        wr_csr(CSR_TCOUNT0 + 13'd2, 32'd1);
        step();
        global_ie = 1;
        wait_req("prio_req", n);
        check("prio_hi", irq_cause, 32'h81);
        ack_rti();
        wait_req("prio_req2", n);
        check("prio_lo", irq_cause, 32'h83);
        ack_rti();
        irq_in = 0;

        // stall holds off the ack
        irq_in[2] = 1;
        wait_req("stall_req", n);
        for (int i = 0; i < 3; i++) begin
            stall = 1; irq_ack = 1;
            step();
            check("stall_hold", irq_req, 1'b1);
        end
        stall = 0;
        step();
        check("stall_acc", irq_req, 1'b0);
        idle_in();
        irq_rti = 1; step(); idle_in();
        rd_csr(CSR_ICAUSE, d);
        check("icause_84", d, 32'h84);

        // withdraw by W1C while requesting
        irq_in = 0; step();
        irq_in[2] = 1;
        wait_req("wd_req", n);
        check("wd_cause", irq_cause, 32'h84);
        wr_csr(CSR_IPEND, 32'h10);
        check("wd_drop", irq_req, 1'b0);
        step();
        rd_csr(CSR_ICAUSE, d);
        check("wd_icause", d, 32'h84);

        // vector for source 2
        irq_in = 0;
        wr_csr(CSR_IPEND, 32'hffffffff);
        wr_csr(CSR_INTVEC, 32'h1000);
        irq_in[0] = 1;
        wait_req("vec_req", n);
        check("vec_cause", irq_cause, 32'h82);
`ifdef CPU_IRQ_VECTORED_EN
        check("vec_addr", irq_vector, 32'h1020);
`else
        check("vec_addr", irq_vector, 32'h1000);
`endif
        ack_rti();

        // reset while requesting
        irq_in = 0; step();
        irq_in[0] = 1;
        wait_req("rst_mid_req", n);
        reset = 1; step();
        check("rst_mid_drop", irq_req, 1'b0);
        reset = 0; irq_in = 0;

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            idle_in();
            reset     = ($urandom_range(0, 499) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            global_ie = ($urandom_range(0, 7) != 0);
            irq_ack   = $urandom_range(0, 1) == 1;
            irq_rti   = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < NE; i++)
                if ($urandom_range(0, 3) == 0) irq_in[i] = ~irq_in[i];
            if ($urandom_range(0, 3) == 0) begin
                int s;
                s = $urandom_range(0, 7);
                csr_we    = 1;
                csr_wdata = $urandom;
                csr_addr  = (s < 4) ? 13'(16 + s) : 13'(32 + s - 4);
                if (s >= 4) csr_wdata = $urandom_range(0, 12);
            end else begin
                csr_addr = 13'($urandom_range(0, 47));
            end
            csr_re = $urandom_range(0, 1) == 1;
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
